// File: rtl/bus_arbiter.sv
// bus_arbiter: two-core round-robin arbiter for a single memory port, with snoop broadcast.
// Optional feature: define BUS_TIMEOUT_EN to abort accesses after 15 BUSY cycles without mem_ack.
`default_nettype none

module bus_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  snoop_valid,
  output logic                  snoop_src
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                owner_q, owner_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                snoop_valid_q, snoop_valid_d;
  logic                snoop_src_q, snoop_src_d;
  logic                win;

`ifdef BUS_TIMEOUT_EN
  logic                err_q, err_d;
  logic [3:0]          tmo_q, tmo_d;
`endif

  // The pointed core has priority; otherwise the other core takes the bus.
  assign win = req[ptr_q] ? ptr_q : ~ptr_q;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    gnt_d         = 2'b00;
    done_d        = 2'b00;
    rdata_d       = rdata_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    snoop_valid_d = 1'b0;
    snoop_src_d   = snoop_src_q;
`ifdef BUS_TIMEOUT_EN
    err_d         = 1'b0;
    tmo_d         = 4'd0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d       = BUSY;
          owner_d       = win;
          gnt_d[win]    = 1'b1;
          mem_req_d     = 1'b1;
          mem_we_d      = we[win];
          mem_addr_d    = win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
          mem_wdata_d   = win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
          snoop_valid_d = 1'b1;
          snoop_src_d   = win;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d          = RESP;
          mem_req_d        = 1'b0;
          done_d[owner_q]  = 1'b1;
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
`ifdef BUS_TIMEOUT_EN
        end else if (tmo_q == 4'd14) begin
          // Fifteenth BUSY cycle without an acknowledge: give up.
          state_d          = RESP;
          mem_req_d        = 1'b0;
          done_d[owner_q]  = 1'b1;
          rdata_d          = '0;
          err_d            = 1'b1;
        end else begin
          tmo_d = tmo_q + 4'd1;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = ~owner_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= 1'b0;
      owner_q       <= 1'b0;
      gnt_q         <= 2'b00;
      done_q        <= 2'b00;
      rdata_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      snoop_valid_q <= 1'b0;
      snoop_src_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      snoop_valid_q <= snoop_valid_d;
      snoop_src_q   <= snoop_src_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      tmo_q <= 4'd0;
    end else begin
      err_q <= err_d;
      tmo_q <= tmo_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign snoop_valid = snoop_valid_q;
  assign snoop_src   = snoop_src_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vectors with hand-computed expectations for bus_arbiter.
`default_nettype none

module tb_bus_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           req;
  logic [1:0]           we;
  logic [2*ADDR_W-1:0]  addr;
  logic [2*DATA_W-1:0]  wdata;
  logic [1:0]           gnt;
  logic [1:0]           done;
  logic [DATA_W-1:0]    rdata;
  logic                 err;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic                 mem_ack;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 snoop_valid;
  logic                 snoop_src;

  int n_vec = 0;
  int n_err = 0;

  bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .gnt         (gnt),
    .done        (done),
    .rdata       (rdata),
    .err         (err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .snoop_valid (snoop_valid),
    .snoop_src   (snoop_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] gseq [4];
  int         ng;

  initial begin
    rst_n     = 1'b0;
    req       = 2'b00;
    we        = 2'b00;
    addr      = '0;
    wdata     = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    ng        = 0;

    tick;
    tick;
    check("rst_gnt",     gnt, 2'b00);
    check("rst_done",    done, 2'b00);
    check("rst_rdata",   rdata, 0);
    check("rst_err",     err, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_addr",    mem_addr, 0);
    check("rst_snoop",   snoop_valid, 0);
    rst_n = 1'b1;
    tick;

    // Core 0 write, ack two cycles after mem_req rises.
    req   = 2'b01;
    we    = 2'b01;
    addr  = {9'h000, 9'h005};
    wdata = {32'h0, 32'hDEADBEEF};
    tick;
    check("wr_gnt",       gnt, 2'b01);
    check("wr_snoop_v",   snoop_valid, 1);
    check("wr_snoop_src", snoop_src, 0);
    check("wr_mem_req",   mem_req, 1);
    check("wr_mem_we",    mem_we, 1);
    check("wr_mem_addr",  mem_addr, 9'h005);
    check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick;
    check("wr_gnt_pulse", gnt, 2'b00);
    check("wr_snoop_pls", snoop_valid, 0);
    check("wr_busy_req",  mem_req, 1);
    check("wr_busy_done", done, 2'b00);
    tick;
    check("wr_hold_req",  mem_req, 1);
    check("wr_hold_addr", mem_addr, 9'h005);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    req     = 2'b00;
    check("wr_done",      done, 2'b01);
    check("wr_err",       err, 0);
    check("wr_rdata",     rdata, 0);
    check("wr_req_drop",  mem_req, 0);
    tick;
    check("wr_done_pls",  done, 2'b00);

    // Core 1 read of 0x1FF.
    req       = 2'b10;
    we        = 2'b00;
    addr      = {9'h1FF, 9'h000};
    tick;
    check("rd_gnt",       gnt, 2'b10);
    check("rd_snoop_src", snoop_src, 1);
    check("rd_mem_addr",  mem_addr, 9'h1FF);
    check("rd_mem_we",    mem_we, 0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    tick;
    mem_ack = 1'b0;
    req     = 2'b00;
    check("rd_done",      done, 2'b10);
    check("rd_rdata",     rdata, 32'h12345678);
    tick;
    check("rd_done_pls",  done, 2'b00);

    // Stray acknowledge while idle must be ignored.
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF0000;
    tick;
    mem_ack = 1'b0;
    tick;
    check("idle_ack_done",  done, 2'b00);
    check("idle_ack_rdata", rdata, 32'h12345678);
    check("idle_ack_req",   mem_req, 0);

    // Contention: both cores request continuously, memory always acks.
    req     = 2'b11;
    we      = 2'b11;
    mem_ack = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick;
      check("cont_gnt_1hot",  $countones(gnt) > 1, 0);
      check("cont_done_1hot", $countones(done) > 1, 0);
      if (gnt != 2'b00 && ng < 4) begin
        gseq[ng] = gnt;
        ng++;
      end
    end
    check("cont_ngrants", ng, 4);
    check("cont_g0", gseq[0], 2'b01);
    check("cont_g1", gseq[1], 2'b10);
    check("cont_g2", gseq[2], 2'b01);
    check("cont_g3", gseq[3], 2'b10);
    req = 2'b00;
    tick;
    tick;
    tick;
    mem_ack = 1'b0;
    tick;
    check("cont_drained", mem_req, 0);

    // Core 0 drops req right after its grant; transfer still completes.
    req   = 2'b01;
    we    = 2'b00;
    addr  = {9'h000, 9'h0AA};
    tick;
    check("drop_gnt", gnt, 2'b01);
    req = 2'b00;
    tick;
    check("drop_busy", mem_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    tick;
    mem_ack = 1'b0;
    check("drop_done",  done, 2'b01);
    check("drop_rdata", rdata, 32'hA5A5A5A5);
    tick;

    // Reset in the middle of a core 1 transfer.
    req = 2'b10;
    tick;
    check("rstb_gnt", gnt, 2'b10);
    tick;
    check("rstb_busy", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("rstb_req_now", mem_req, 0);
    check("rstb_done_now", done, 2'b00);
    req       = 2'b11;
    we        = 2'b00;
    mem_rdata = 32'h55AA55AA;
    tick;
    check("rstb_done", done, 2'b00);
    check("rstb_rdata", rdata, 0);
    rst_n = 1'b1;
    tick;
    check("rstb_next_gnt", gnt, 2'b01);
    check("rstb_next_src", snoop_src, 0);
    req     = 2'b00;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    check("rstb_post_done",  done, 2'b01);
    check("rstb_post_rdata", rdata, 32'h55AA55AA);
    tick;

    // No acknowledge from memory.
    req   = 2'b01;
    we    = 2'b01;
    wdata = {32'h0, 32'h0BADF00D};
    tick;
    check("tmo_gnt", gnt, 2'b01);
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      tick;
      check("tmo_wait_req",  mem_req, 1);
      check("tmo_wait_done", done, 2'b00);
    end
    tick;
    req = 2'b00;
    check("tmo_done",  done, 2'b01);
    check("tmo_err",   err, 1);
    check("tmo_rdata", rdata, 0);
    check("tmo_req",   mem_req, 0);
    tick;
    check("tmo_done_pls", done, 2'b00);
    check("tmo_err_pls",  err, 0);
`else
    for (int i = 0; i < 40; i++) begin
      tick;
      check("hang_req",  mem_req, 1);
      check("hang_done", done, 2'b00);
    end
    req     = 2'b00;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    check("hang_done_end", done, 2'b01);
    check("hang_err",      err, 0);
    check("hang_rdata",    rdata, 32'h55AA55AA);
    tick;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
